// File: rtl/dsp_pkg.sv
// Shared widths and FSM encoding for the signed restoring divider.
// Default operand width; the top recomputes widths from its own DW parameter.
package dsp_pkg;
   localparam int DW_DEF = 8;
   localparam int DVD_W  = 2*DW_DEF+1;
   localparam int QUO_W  = DW_DEF+1;
   localparam int CNT_W  = $clog2(2*DW_DEF+1);

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
endpackage

// File: rtl/dsp_div_if.sv
// Operand/result stream bundle for dsp_div; slave is the divider's view.
interface dsp_div_if #(
   parameter int DW = 8
);
   logic                 s_tvalid;
   logic                 s_tready;
   logic signed [2*DW:0] s_dividend;
   logic signed [DW-1:0] s_divisor;
   logic                 m_tvalid;
   logic                 m_tready;
   logic signed [DW:0]   m_quotient;
   logic signed [DW-1:0] m_remainder;
   logic                 m_div_by_zero;
   logic                 m_overflow;

   modport slave (
      input  s_tvalid, s_dividend, s_divisor, m_tready,
      output s_tready, m_tvalid, m_quotient, m_remainder, m_div_by_zero, m_overflow
   );

   modport master (
      output s_tvalid, s_dividend, s_divisor, m_tready,
      input  s_tready, m_tvalid, m_quotient, m_remainder, m_div_by_zero, m_overflow
   );
endinterface

// File: rtl/dsp_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the partial remainder is always below the divisor on entry.
module dsp_div_step #(
   parameter int DW = 8
) (
   input  logic [DW:0]   i_rem,
   input  logic          i_bit,
   input  logic [DW-1:0] i_dvs,
   output logic [DW:0]   o_rem,
   output logic          o_qbit
);
   logic [DW+1:0] w_shift;
   logic [DW:0]   w_diff;

   assign w_shift = {i_rem, i_bit};
   assign o_qbit  = (w_shift >= {2'b00, i_dvs});
   // Only taken when no borrow, so the low DW+1 bits hold the exact difference.
   assign w_diff  = w_shift[DW:0] - {1'b0, i_dvs};
   assign o_rem   = o_qbit ? w_diff : w_shift[DW:0];
endmodule

// File: rtl/dsp_div.sv
// Sequential signed truncating divider: 2*DW+1-bit dividend by DW-bit divisor, one quotient bit per cycle.
// Result valid 2*DW+2 edges after accept (1 for divide-by-zero); result held until m_tready, no overlap.
module dsp_div
   import dsp_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input logic     clk,
   input logic     rst_n,
   dsp_div_if.slave bus
);
   localparam int N  = 2*DW+1;
   localparam int CW = $clog2(N);

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [N-1:0]         r_dvd;
   logic [DW-1:0]        r_dvs;
   logic [DW:0]          r_rem;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_s_tready;
   logic                 r_m_tvalid;
   logic [DW:0]          r_q;
   logic [DW-1:0]        r_r;
   logic                 r_dbz;
   logic                 r_ovf;

   logic [N-1:0]         w_dvd_raw;
   logic [N-1:0]         w_dvd_mag;
   logic [DW-1:0]        w_dvs_raw;
   logic [DW-1:0]        w_dvs_mag;
   logic [DW:0]          w_rem_nxt;
   logic                 w_qbit;
   logic signed [N:0]    w_q_s;
   logic                 w_q_fits;
   logic [DW-1:0]        w_r_s;

   assign w_dvd_raw = bus.s_dividend;
   assign w_dvs_raw = bus.s_divisor;
   assign w_dvd_mag = w_dvd_raw[N-1]  ? -w_dvd_raw : w_dvd_raw;
   assign w_dvs_mag = w_dvs_raw[DW-1] ? -w_dvs_raw : w_dvs_raw;

   // Dividend register doubles as the quotient: bits leave at the MSB, quotient bits enter at the LSB.
   dsp_div_step #(.DW(DW)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_dvd[N-1]),
      .i_dvs  (r_dvs),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   assign w_q_s    = r_neg_q ? -{1'b0, r_dvd} : {1'b0, r_dvd};
   assign w_q_fits = (&w_q_s[N:DW]) | ~(|w_q_s[N:DW]);
   assign w_r_s    = r_neg_r ? -r_rem[DW-1:0] : r_rem[DW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_rem      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_s_tready <= 1'b1;
         r_m_tvalid <= 1'b0;
         r_q        <= '0;
         r_r        <= '0;
         r_dbz      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.s_tvalid && r_s_tready) begin
                  r_s_tready <= 1'b0;
                  r_dvd      <= w_dvd_mag;
                  r_dvs      <= w_dvs_mag;
                  r_neg_q    <= w_dvd_raw[N-1] ^ w_dvs_raw[DW-1];
                  r_neg_r    <= w_dvd_raw[N-1];
                  r_rem      <= '0;
                  r_cnt      <= CW'(N-1);
                  if (w_dvs_raw == '0) begin
                     r_state    <= DONE;
                     r_m_tvalid <= 1'b1;
                     r_q        <= '0;
                     r_r        <= '0;
                     r_dbz      <= 1'b1;
                     r_ovf      <= 1'b0;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_dvd <= {r_dvd[N-2:0], w_qbit};
               if (r_cnt == '0) r_state <= SIGN;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            SIGN: begin
               r_q        <= w_q_s[DW:0];
               r_r        <= w_r_s;
               r_dbz      <= 1'b0;
               r_ovf      <= ~w_q_fits;
               r_m_tvalid <= 1'b1;
               r_state    <= DONE;
            end
            DONE: begin
               if (bus.m_tready) begin
                  r_m_tvalid <= 1'b0;
                  r_s_tready <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_tready      = r_s_tready;
   assign bus.m_tvalid      = r_m_tvalid;
   assign bus.m_quotient    = r_q;
   assign bus.m_remainder   = r_r;
   assign bus.m_div_by_zero = r_dbz;
   assign bus.m_overflow    = r_ovf;
endmodule
